// File: rtl/fetch_decode_skid_buffer_if.sv
// rtl/fetch_decode_skid_buffer_if.sv - fetch/decode handshake bundle for the IF/ID skid buffer
interface fetch_decode_skid_buffer_if #(
  parameter int XLEN = 32
);
  logic            valid_f;
  logic            ready_f;
  logic [XLEN-1:0] instr_f;
  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pcplus4_f;

  logic            valid_d;
  logic            ready_d;
  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pcplus4_d;

  // master drives fetch payload and decode ready; slave is the buffer itself
  modport master (
    output valid_f, instr_f, pc_f, pcplus4_f, ready_d,
    input  ready_f, valid_d, instr_d, pc_d, pcplus4_d
  );

  modport slave (
    input  valid_f, instr_f, pc_f, pcplus4_f, ready_d,
    output ready_f, valid_d, instr_d, pc_d, pcplus4_d
  );
endinterface

// File: rtl/fetch_decode_skid_buffer.sv
// rtl/fetch_decode_skid_buffer.sv - 2-entry IF/ID skid buffer with NOP bubbles and stall counter
module fetch_decode_skid_buffer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 'h00000013,
  parameter int              CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  fetch_decode_skid_buffer_if.slave   bus,
  input  logic                        flush,
  output logic [1:0]                  occupancy,
  output logic [CNT_W-1:0]            stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  localparam entry_t          BUBBLE  = {NOP_INSTR, {XLEN{1'b0}}, {XLEN{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   main_valid_q;
  logic   ready_f_q;
  logic   in_fire;
  logic   out_fire;

  assign in_entry = {bus.instr_f, bus.pc_f, bus.pcplus4_f};
  assign in_fire  = bus.valid_f & ready_f_q;
  assign out_fire = main_valid_q & bus.ready_d;

  assign bus.ready_f   = ready_f_q;
  assign bus.valid_d   = main_valid_q;
  assign bus.instr_d   = main_q.instr;
  assign bus.pc_d      = main_q.pc;
  assign bus.pcplus4_d = main_q.pcplus4;

  // ready_f comes straight from a flop so ready_d never reaches fetch combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      main_q       <= BUBBLE;
      skid_q       <= BUBBLE;
      main_valid_q <= 1'b0;
      ready_f_q    <= 1'b1;
      occupancy    <= 2'd0;
    end else if (flush) begin
      state        <= EMPTY;
      main_q       <= BUBBLE;
      main_valid_q <= 1'b0;
      ready_f_q    <= 1'b1;
      occupancy    <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state        <= ONE;
            main_q       <= in_entry;
            main_valid_q <= 1'b1;
            occupancy    <= 2'd1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_entry;
          end else if (in_fire) begin
            state     <= FULL;
            skid_q    <= in_entry;
            ready_f_q <= 1'b0;
            occupancy <= 2'd2;
          end else if (out_fire) begin
            state        <= EMPTY;
            main_q       <= BUBBLE;
            main_valid_q <= 1'b0;
            occupancy    <= 2'd0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state     <= ONE;
            main_q    <= skid_q;
            ready_f_q <= 1'b1;
            occupancy <= 2'd1;
          end
        end
        default: begin
          state        <= EMPTY;
          main_q       <= BUBBLE;
          main_valid_q <= 1'b0;
          ready_f_q    <= 1'b1;
          occupancy    <= 2'd0;
        end
      endcase
    end
  end

  // flush does not clear the counter; it only suppresses counting that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (main_valid_q && !bus.ready_d && !flush && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_decode_skid_buffer.sv
// tb/tb_fetch_decode_skid_buffer.sv - scoreboard bench for fetch_decode_skid_buffer
module tb_fetch_decode_skid_buffer;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } ent_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [1:0] occupancy;
  logic [3:0] stall_cnt;

  fetch_decode_skid_buffer_if #(.XLEN(32)) bus ();

  fetch_decode_skid_buffer #(
    .XLEN     (32),
    .NOP_INSTR(NOP),
    .CNT_W    (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .flush    (flush),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_occ   = 0;
  int   m_stall = 0;
  ent_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: compares against the occupancy model and pops the scoreboard on each delivery
  initial begin
    ent_t e;
    bit   in_f;
    bit   out_f;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_occ   = 0;
        m_stall = 0;
        exp_q.delete();
      end else begin
        chk("valid_d",   {31'd0, bus.valid_d}, {31'd0, m_occ != 0});
        chk("ready_f",   {31'd0, bus.ready_f}, {31'd0, m_occ < 2});
        chk("occupancy", {30'd0, occupancy}, m_occ);
        chk("stall_cnt", {28'd0, stall_cnt}, m_stall);
        if (m_occ == 0) begin
          chk("bubble_instr", bus.instr_d, NOP);
          chk("bubble_pc",    bus.pc_d, 32'd0);
          chk("bubble_pcp4",  bus.pcplus4_d, 32'd0);
        end
        if (m_occ != 0 && bus.ready_d && !flush) begin
          if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("instr_d",   bus.instr_d, e.instr);
            chk("pc_d",      bus.pc_d, e.pc);
            chk("pcplus4_d", bus.pcplus4_d, e.pcp4);
          end
        end
        in_f  = bus.valid_f && (m_occ < 2);
        out_f = (m_occ != 0) && bus.ready_d;
        if (m_occ != 0 && !bus.ready_d && !flush && m_stall < 15) m_stall++;
        if (flush) m_occ = 0;
        else       m_occ = m_occ + int'(in_f) - int'(out_f);
      end
    end
  end

  task automatic step(input logic vf, input logic [31:0] pc, input logic rd, input logic fl);
    ent_t e;
    @(posedge clk);
    #1;
    bus.valid_f   = vf;
    bus.instr_f   = vf ? {8'hA5, pc[23:0]} : 'x;
    bus.pc_f      = vf ? pc : 'x;
    bus.pcplus4_f = vf ? pc + 32'd4 : 'x;
    bus.ready_d   = rd;
    flush         = fl;
    if (fl) begin
      exp_q.delete();
    end else if (vf && m_occ < 2) begin
      e.instr = {8'hA5, pc[23:0]};
      e.pc    = pc;
      e.pcp4  = pc + 32'd4;
      exp_q.push_back(e);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid_d"},   {31'd0, bus.valid_d}, 32'd0);
    chk({tag, "_instr_d"},   bus.instr_d, NOP);
    chk({tag, "_pc_d"},      bus.pc_d, 32'd0);
    chk({tag, "_pcplus4_d"}, bus.pcplus4_d, 32'd0);
    chk({tag, "_ready_f"},   {31'd0, bus.ready_f}, 32'd1);
    chk({tag, "_occupancy"}, {30'd0, occupancy}, 32'd0);
    chk({tag, "_stall_cnt"}, {28'd0, stall_cnt}, 32'd0);
  endtask

  initial begin
    logic [31:0] pc;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.valid_f   = 1'b0;
    bus.ready_d   = 1'b0;
    bus.instr_f   = '0;
    bus.pc_f      = '0;
    bus.pcplus4_f = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    rst_n = 1'b1;

    // streaming
    for (int k = 0; k < 8; k++) step(1'b1, 32'(k * 4), 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    at_neg();
    chk("stream_last_pc", bus.pc_d, 32'h1C);
    chk("stream_occ", {30'd0, occupancy}, 32'd1);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // back-pressure
    step(1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'h104, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    at_neg();
    chk("bp_occ_full", {30'd0, occupancy}, 32'd2);
    chk("bp_ready_f", {31'd0, bus.ready_f}, 32'd0);
    chk("bp_pc_held", bus.pc_d, 32'h100);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    at_neg();
    chk("bp_first_out", bus.pc_d, 32'h100);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    at_neg();
    chk("bp_second_out", bus.pc_d, 32'h104);
    chk("bp_ready_back", {31'd0, bus.ready_f}, 32'd1);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    at_neg();
    chk("bp_empty_nop", bus.instr_d, NOP);

    // flush while FULL with a concurrent fetch
    step(1'b1, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h304, 1'b0, 1'b0);
    step(1'b1, 32'h200, 1'b0, 1'b1);
    at_neg();
    chk("fl_pre_occ", {30'd0, occupancy}, 32'd2);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    at_neg();
    chk("fl_valid_d", {31'd0, bus.valid_d}, 32'd0);
    chk("fl_instr_nop", bus.instr_d, NOP);
    chk("fl_occ", {30'd0, occupancy}, 32'd0);
    step(1'b1, 32'h204, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    at_neg();
    chk("fl_after_pc", bus.pc_d, 32'h204);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // async reset while FULL
    step(1'b1, 32'h500, 1'b0, 1'b0);
    step(1'b1, 32'h504, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    at_neg();
    chk("rst_pre_occ", {30'd0, occupancy}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    m_occ   = 0;
    m_stall = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus.valid_f = 1'b0;
    bus.ready_d = 1'b0;
    flush       = 1'b0;

    // stall counter saturation at 4 bits
    step(1'b1, 32'h400, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
    at_neg();
    chk("stall_partial", {28'd0, stall_cnt}, 32'd5);
    for (int i = 0; i < 14; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
    at_neg();
    chk("stall_sat", {28'd0, stall_cnt}, 32'd15);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    at_neg();
    chk("stall_after_flush", {28'd0, stall_cnt}, 32'd15);

    // random traffic
    pc = 32'h1000;
    for (int i = 0; i < 10000; i++) begin
      step(($urandom % 4) != 0, pc, ($urandom % 3) != 0, ($urandom % 32) == 0);
      pc = pc + 32'd4;
    end
    repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0);
    at_neg();
    chk("drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
